// File: rtl/sm83_fetch_if.sv
// ============================================================================
// sm83_fetch_if
// Bus/handshake bundle between the SM83 fetch stage, memory and decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sm83_fetch_if;
    logic        fetch_en;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic        instr_cb;
    logic [15:0] instr_imm;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic        instr_illegal;

    // The fetch stage is the bus master and the bundle producer.
    modport master (
        input  fetch_en, redirect, redirect_pc,
        input  mem_rdata, mem_ack, instr_ready,
        output mem_req, mem_addr,
        output instr_valid, instr_op, instr_cb, instr_imm,
        output instr_len, instr_pc, instr_illegal
    );

    modport slave (
        output fetch_en, redirect, redirect_pc,
        output mem_rdata, mem_ack, instr_ready,
        input  mem_req, mem_addr,
        input  instr_valid, instr_op, instr_cb, instr_imm,
        input  instr_len, instr_pc, instr_illegal
    );
endinterface

`default_nettype wire

// File: rtl/sm83_fetch.sv
// ============================================================================
// sm83_fetch
// SM83 instruction fetch: opcode, CB prefix and immediates into one bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sm83_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    sm83_fetch_if.master    bus
);

    typedef enum logic [2:0] {
        ST_OP     = 3'd0,
        ST_CB     = 3'd1,
        ST_IMM_LO = 3'd2,
        ST_IMM_HI = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    localparam logic [7:0] C_PREFIX_CB = 8'hCB;

    state_t      r_state;
    logic [15:0] r_fpc;
    logic [15:0] r_target;
    logic        r_mem_req;
    logic        r_valid;
    logic [7:0]  r_op;
    logic        r_cb;
    logic [15:0] r_imm;
    logic [1:0]  r_len;
    logic [15:0] r_pc;
    logic        r_illegal;

    logic [7:0]  w_byte;
    logic [1:0]  w_dec_len;
    logic        w_dec_illegal;

    assign w_byte = bus.mem_rdata;

    always_comb begin
        w_dec_len = 2'd1;
        casez (w_byte)
            8'b00??_0001, 8'h08, 8'b110?_?010, 8'hC3,
            8'b110?_?100, 8'hCD, 8'hEA, 8'hFA:
                w_dec_len = 2'd3;
            8'b00??_?110, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'b11??_?110, 8'hE0, 8'hF0, 8'hE8, 8'hF8:
                w_dec_len = 2'd2;
            default:
                w_dec_len = 2'd1;
        endcase
    end

    always_comb begin
        w_dec_illegal = 1'b0;
        case (w_byte)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:
                w_dec_illegal = 1'b1;
            default:
                w_dec_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_OP;
            r_fpc     <= RESET_PC;
            r_target  <= RESET_PC;
            r_mem_req <= 1'b0;
            r_valid   <= 1'b0;
            r_op      <= 8'h00;
            r_cb      <= 1'b0;
            r_imm     <= 16'h0000;
            r_len     <= 2'd0;
            r_pc      <= 16'h0000;
            r_illegal <= 1'b0;
        end else if (bus.redirect) begin
            // An outstanding read must finish on the bus before the new PC is used.
            if (r_mem_req && !bus.mem_ack) begin
                r_state  <= ST_DRAIN;
                r_target <= bus.redirect_pc;
            end else begin
                r_state   <= ST_OP;
                r_fpc     <= bus.redirect_pc;
                r_mem_req <= bus.fetch_en;
                r_valid   <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_OP: begin
                    if (!r_mem_req) begin
                        r_mem_req <= bus.fetch_en;
                    end else if (bus.mem_ack) begin
                        r_fpc <= r_fpc + 16'd1;
                        r_pc  <= r_fpc;
                        r_op  <= w_byte;
                        r_cb  <= 1'b0;
                        r_imm <= 16'h0000;
                        if (w_byte == C_PREFIX_CB) begin
                            r_state   <= ST_CB;
                            r_len     <= 2'd2;
                            r_illegal <= 1'b0;
                        end else begin
                            r_len     <= w_dec_len;
                            r_illegal <= w_dec_illegal;
                            if (w_dec_len == 2'd1) begin
                                r_state   <= ST_HOLD;
                                r_mem_req <= 1'b0;
                                r_valid   <= 1'b1;
                            end else begin
                                r_state <= ST_IMM_LO;
                            end
                        end
                    end
                end
                ST_CB: begin
                    if (bus.mem_ack) begin
                        r_fpc     <= r_fpc + 16'd1;
                        r_op      <= w_byte;
                        r_cb      <= 1'b1;
                        r_state   <= ST_HOLD;
                        r_mem_req <= 1'b0;
                        r_valid   <= 1'b1;
                    end
                end
                ST_IMM_LO: begin
                    if (bus.mem_ack) begin
                        r_fpc      <= r_fpc + 16'd1;
                        r_imm[7:0] <= w_byte;
                        if (r_len == 2'd3) begin
                            r_state <= ST_IMM_HI;
                        end else begin
                            r_state   <= ST_HOLD;
                            r_mem_req <= 1'b0;
                            r_valid   <= 1'b1;
                        end
                    end
                end
                ST_IMM_HI: begin
                    if (bus.mem_ack) begin
                        r_fpc       <= r_fpc + 16'd1;
                        r_imm[15:8] <= w_byte;
                        r_state     <= ST_HOLD;
                        r_mem_req   <= 1'b0;
                        r_valid     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        r_valid   <= 1'b0;
                        r_state   <= ST_OP;
                        r_mem_req <= bus.fetch_en;
                    end
                end
                ST_DRAIN: begin
                    if (bus.mem_ack) begin
                        r_fpc     <= r_target;
                        r_state   <= ST_OP;
                        r_mem_req <= bus.fetch_en;
                    end
                end
                default: begin
                    r_state   <= ST_OP;
                    r_mem_req <= 1'b0;
                    r_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req       = r_mem_req;
    assign bus.mem_addr      = r_fpc;
    assign bus.instr_valid   = r_valid;
    assign bus.instr_op      = r_op;
    assign bus.instr_cb      = r_cb;
    assign bus.instr_imm     = r_imm;
    assign bus.instr_len     = r_len;
    assign bus.instr_pc      = r_pc;
    assign bus.instr_illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_sm83_fetch.sv
// ============================================================================
// tb_sm83_fetch
// Directed vector bench for sm83_fetch with a byte-array memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sm83_fetch;

    localparam logic [15:0] C_RESET_PC = 16'h0100;
    localparam int          C_NVEC     = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sm83_fetch_if bus();

    sm83_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: ack after 'waits' wait cycles, data read at mem_addr.
    logic [7:0]  mem [0:65535];
    int unsigned waits = 0;
    int unsigned wcnt  = 0;

    assign bus.mem_ack   = bus.mem_req && (wcnt >= waits);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [1:0]  len;
        logic [7:0]  op;
        logic        cb;
        logic [15:0] imm;
        logic        ill;
    } vec_t;

    vec_t        vecs [C_NVEC];
    logic [15:0] vpc  [C_NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input logic [7:0] op, input logic cb,
                              input logic [15:0] imm, input logic [1:0] len,
                              input logic [15:0] pc, input logic ill);
        check({tag, ".valid"},   32'(bus.instr_valid),   32'd1);
        check({tag, ".op"},      32'(bus.instr_op),      32'(op));
        check({tag, ".cb"},      32'(bus.instr_cb),      32'(cb));
        check({tag, ".imm"},     32'(bus.instr_imm),     32'(imm));
        check({tag, ".len"},     32'(bus.instr_len),     32'(len));
        check({tag, ".pc"},      32'(bus.instr_pc),      32'(pc));
        check({tag, ".illegal"}, 32'(bus.instr_illegal), 32'(ill));
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic [15:0] addr,
                           input logic valid);
        check({tag, ".mem_req"},  32'(bus.mem_req),     32'(req));
        check({tag, ".mem_addr"}, 32'(bus.mem_addr),    32'(addr));
        check({tag, ".valid"},    32'(bus.instr_valid), 32'(valid));
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.instr_valid && cycles < 50);
        if (!bus.instr_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got no instr_valid, expected one within 50 cycles", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] e;
        int          cyc;

        vecs[0]  = '{8'h00, 8'h00, 8'h00, 2'd1, 8'h00, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{8'h21, 8'h34, 8'h12, 2'd3, 8'h21, 1'b0, 16'h1234, 1'b0};
        vecs[2]  = '{8'hCB, 8'h37, 8'h00, 2'd2, 8'h37, 1'b1, 16'h0000, 1'b0};
        vecs[3]  = '{8'h3E, 8'h55, 8'h00, 2'd2, 8'h3E, 1'b0, 16'h0055, 1'b0};
        vecs[4]  = '{8'hD3, 8'h00, 8'h00, 2'd1, 8'hD3, 1'b0, 16'h0000, 1'b1};
        vecs[5]  = '{8'hC3, 8'h00, 8'h02, 2'd3, 8'hC3, 1'b0, 16'h0200, 1'b0};
        vecs[6]  = '{8'h18, 8'hFE, 8'h00, 2'd2, 8'h18, 1'b0, 16'h00FE, 1'b0};
        vecs[7]  = '{8'hE0, 8'h44, 8'h00, 2'd2, 8'hE0, 1'b0, 16'h0044, 1'b0};
        vecs[8]  = '{8'hCD, 8'h34, 8'h12, 2'd3, 8'hCD, 1'b0, 16'h1234, 1'b0};
        vecs[9]  = '{8'h08, 8'hAA, 8'hBB, 2'd3, 8'h08, 1'b0, 16'hBBAA, 1'b0};
        vecs[10] = '{8'h76, 8'h00, 8'h00, 2'd1, 8'h76, 1'b0, 16'h0000, 1'b0};
        vecs[11] = '{8'hFD, 8'h00, 8'h00, 2'd1, 8'hFD, 1'b0, 16'h0000, 1'b1};
        vecs[12] = '{8'hCB, 8'hC7, 8'h00, 2'd2, 8'hC7, 1'b1, 16'h0000, 1'b0};
        vecs[13] = '{8'hF8, 8'h05, 8'h00, 2'd2, 8'hF8, 1'b0, 16'h0005, 1'b0};
        vecs[14] = '{8'hC6, 8'h12, 8'h00, 2'd2, 8'hC6, 1'b0, 16'h0012, 1'b0};
        vecs[15] = '{8'h01, 8'hEF, 8'hBE, 2'd3, 8'h01, 1'b0, 16'hBEEF, 1'b0};
        vecs[16] = '{8'hCA, 8'h11, 8'h22, 2'd3, 8'hCA, 1'b0, 16'h2211, 1'b0};
        vecs[17] = '{8'hE2, 8'h00, 8'h00, 2'd1, 8'hE2, 1'b0, 16'h0000, 1'b0};
        vecs[18] = '{8'hDD, 8'h00, 8'h00, 2'd1, 8'hDD, 1'b0, 16'h0000, 1'b1};
        vecs[19] = '{8'h36, 8'h99, 8'h00, 2'd2, 8'h36, 1'b0, 16'h0099, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        a = C_RESET_PC;
        for (int i = 0; i < C_NVEC; i++) begin
            vpc[i] = a;
            mem[a] = vecs[i].b0;
            if (vecs[i].len > 2'd1) mem[a + 16'd1] = vecs[i].b1;
            if (vecs[i].len > 2'd2) mem[a + 16'd2] = vecs[i].b2;
            a = a + 16'(vecs[i].len);
        end
        e = a;
        mem[e]          = 8'h06;
        mem[e + 16'd1]  = 8'h77;
        mem[e + 16'd2]  = 8'hCB;
        mem[e + 16'd3]  = 8'h37;
        mem[e + 16'd4]  = 8'h3E;
        mem[e + 16'd5]  = 8'h99;
        mem[16'h0038]   = 8'hAF;
        mem[16'hFFFF]   = 8'h3E;
        mem[16'h0000]   = 8'h55;
        mem[16'h0001]   = 8'hD3;
        mem[16'h0002]   = 8'h00;
        mem[16'h0200]   = 8'hC9;

        bus.fetch_en    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.instr_ready = 1'b1;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_bus("reset", 1'b0, C_RESET_PC, 1'b0);
        check("reset.op",      32'(bus.instr_op),      32'd0);
        check("reset.imm",     32'(bus.instr_imm),     32'd0);
        check("reset.pc",      32'(bus.instr_pc),      32'd0);
        check("reset.cb",      32'(bus.instr_cb),      32'd0);
        check("reset.len",     32'(bus.instr_len),     32'd0);
        check("reset.illegal", 32'(bus.instr_illegal), 32'd0);
        rst_n = 1'b1;

        // Straight-line program with ready held high and a zero-wait bus.
        for (int i = 0; i < C_NVEC; i++) begin
            wait_valid($sformatf("v%0d", i), cyc);
            if (i > 0) check($sformatf("v%0d.latency", i), 32'(cyc), 32'(vecs[i].len) + 32'd1);
            chk_bundle($sformatf("v%0d", i), vecs[i].op, vecs[i].cb, vecs[i].imm,
                       vecs[i].len, vpc[i], vecs[i].ill);
        end

        // Decoder stall: bundle frozen, bus idle, fetch resumes right after ready.
        @(negedge clk);
        bus.instr_ready = 1'b0;
        wait_valid("stall", cyc);
        chk_bundle("stall", 8'h06, 1'b0, 16'h0077, 2'd2, e, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d.valid", k), 32'(bus.instr_valid), 32'd1);
            check($sformatf("stall%0d.req", k),   32'(bus.mem_req),     32'd0);
            check($sformatf("stall%0d.op", k),    32'(bus.instr_op),    32'h06);
            check($sformatf("stall%0d.imm", k),   32'(bus.instr_imm),   32'h0077);
        end
        bus.instr_ready = 1'b1;
        waits = 2;

        // CB-prefixed fetch with two wait states per byte.
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk_bus("resume", 1'b1, e + 16'd2, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk_bus("cbw.prefix", 1'b1, e + 16'd2, 1'b0);
        end
        repeat (3) begin
            @(negedge clk);
            chk_bus("cbw.op", 1'b1, e + 16'd3, 1'b0);
        end
        @(negedge clk);
        chk_bundle("cbw", 8'h37, 1'b1, 16'h0000, 2'd2, e + 16'd2, 1'b0);
        bus.instr_ready = 1'b1;

        // Redirect while the immediate byte read is waiting: drain, then restart.
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk_bus("drn.op", 1'b1, e + 16'd4, 1'b0);
        repeat (3) @(negedge clk);
        chk_bus("drn.imm", 1'b1, e + 16'd5, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0038;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk_bus("drn.wait0", 1'b1, e + 16'd5, 1'b0);
        @(negedge clk);
        chk_bus("drn.wait1", 1'b1, e + 16'd5, 1'b0);
        @(negedge clk);
        chk_bus("drn.new", 1'b1, 16'h0038, 1'b0);
        waits = 0;
        @(negedge clk);
        chk_bundle("drn", 8'hAF, 1'b0, 16'h0000, 2'd1, 16'h0038, 1'b0);

        // Redirect from HOLD (bundle consumed) to 0xFFFF: address wraps mid-instruction.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b0;
        chk_bus("wrap.req", 1'b1, 16'hFFFF, 1'b0);
        repeat (2) @(negedge clk);
        chk_bundle("wrap", 8'h3E, 1'b0, 16'h0055, 2'd2, 16'hFFFF, 1'b0);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk_bus("wrap.next", 1'b1, 16'h0001, 1'b0);
        @(negedge clk);
        chk_bundle("ill", 8'hD3, 1'b0, 16'h0000, 2'd1, 16'h0001, 1'b1);

        // fetch_en low keeps the bus idle in OP until it returns.
        bus.fetch_en    = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_bus("fen.off", 1'b0, 16'h0002, 1'b0);
        end
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        chk_bus("fen.on", 1'b1, 16'h0002, 1'b0);
        @(negedge clk);
        chk_bundle("fen", 8'h00, 1'b0, 16'h0000, 2'd1, 16'h0002, 1'b0);

        // Redirect in HOLD with ready low drops the bundle.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0200;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk_bus("drop", 1'b1, 16'h0200, 1'b0);
        @(negedge clk);
        chk_bundle("drop", 8'hC9, 1'b0, 16'h0000, 2'd1, 16'h0200, 1'b0);

        // Redirect coinciding with a zero-wait ack discards that byte.
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk_bus("coin.pre", 1'b1, 16'h0201, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0038;
        @(negedge clk);
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b0;
        chk_bus("coin.new", 1'b1, 16'h0038, 1'b0);
        @(negedge clk);
        chk_bundle("coin", 8'hAF, 1'b0, 16'h0000, 2'd1, 16'h0038, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
